// File: rtl/load_store_unit.sv
// load_store_unit: converts RV32I loads/stores into whole-word memory accesses.
// Sub-word stores are read-modify-write: the merge happens in the accept cycle
// against mem_read_data, and the merged word is written one cycle later.
// Optional macro LSU_STATS_EN adds saturating load/store/fault counters.
module load_store_unit #(
    parameter int DATA_WIDTH           = 32,
    parameter int MEMORY_ADDRESS_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [2:0]                      req_funct3,
    input  logic [MEMORY_ADDRESS_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    output logic                            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_misaligned,
    output logic                            rsp_illegal,
    output logic [MEMORY_ADDRESS_WIDTH+1:0] mem_address,
    output logic                            mem_write_en,
    output logic [DATA_WIDTH-1:0]           mem_write_data,
    input  logic [DATA_WIDTH-1:0]           mem_read_data
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]                     stat_loads,
    output logic [31:0]                     stat_stores,
    output logic [31:0]                     stat_faults
`endif
);

    localparam int AW = MEMORY_ADDRESS_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr_reg;
    logic [31:0]     wdata_reg;

    logic            accept;
    logic            is_illegal;
    logic            is_misaligned;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [31:0]     load_ext;
    logic [3:0]      lane_wr;
    logic [31:0]     merged;

    assign req_ready      = (state == IDLE);
    assign accept         = req_valid && (state == IDLE);
    // Combinational address in IDLE so the read data is usable in the accept cycle.
    assign mem_address    = (state == IDLE) ? req_addr : addr_reg;
    assign mem_write_data = wdata_reg;

    // Classify the request: illegal encodings first, then alignment faults.
    always_comb begin
        is_illegal    = 1'b0;
        is_misaligned = 1'b0;
        case (req_funct3)
            3'b000:  is_illegal = 1'b0;
            3'b001:  is_misaligned = req_addr[0];
            3'b010:  is_misaligned = (req_addr[1:0] != 2'b00);
            3'b100:  is_illegal = req_we;
            3'b101: begin
                is_illegal    = req_we;
                is_misaligned = req_addr[0];
            end
            default: is_illegal = 1'b1;
        endcase
        if (is_illegal) begin
            is_misaligned = 1'b0;
        end
    end

    // Select the addressed lane from the read word and extend it.
    always_comb begin
        load_byte = mem_read_data[{req_addr[1:0], 3'b000} +: 8];
        load_half = req_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (req_funct3)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'd0, load_byte};
            3'b101:  load_ext = {16'd0, load_half};
            default: load_ext = mem_read_data;
        endcase
    end

    // Which byte lanes a store overwrites.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   lane_wr = 4'b0001 << req_addr[1:0];
            2'b01:   lane_wr = req_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_wr = 4'b1111;
        endcase
    end

    // Per-lane merge: written lanes take store data, the rest keep the old word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] src_byte;
            assign src_byte = req_funct3[1] ? req_wdata[8*gi +: 8]
                            : req_funct3[0] ? req_wdata[8*(gi%2) +: 8]
                            : req_wdata[7:0];
            assign merged[8*gi +: 8] = lane_wr[gi] ? src_byte : mem_read_data[8*gi +: 8];
        end
    endgenerate

    // Main FSM with registered response and write-strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            rsp_illegal    <= 1'b0;
            mem_write_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_illegal || is_misaligned) begin
                            rsp_valid      <= 1'b1;
                            rsp_rdata      <= '0;
                            rsp_illegal    <= is_illegal;
                            rsp_misaligned <= is_misaligned;
                            state          <= RESP;
                        end else if (req_we) begin
                            addr_reg     <= req_addr;
                            wdata_reg    <= merged;
                            mem_write_en <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_ext;
                            state     <= RESP;
                        end
                    end
                end
                WRITE: begin
                    mem_write_en <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= '0;
                    state        <= RESP;
                end
                RESP: begin
                    rsp_valid      <= 1'b0;
                    rsp_rdata      <= '0;
                    rsp_misaligned <= 1'b0;
                    rsp_illegal    <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    mem_write_en <= 1'b0;
                    rsp_valid    <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef LSU_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_faults <= '0;
        end else begin
            if (accept && !req_we && !is_illegal && !is_misaligned && (stat_loads != 32'hFFFF_FFFF)) begin
                stat_loads <= stat_loads + 32'd1;
            end
            if ((state == WRITE) && (stat_stores != 32'hFFFF_FFFF)) begin
                stat_stores <= stat_stores + 32'd1;
            end
            if (accept && (is_illegal || is_misaligned) && (stat_faults != 32'hFFFF_FFFF)) begin
                stat_faults <= stat_faults + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_illegal;
    logic [11:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
`ifdef LSU_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_faults;
`endif

    logic [31:0] mem [0:1023];
    int          vectors = 0;
    int          miscompares = 0;
    int          write_pulses = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .rsp_illegal    (rsp_illegal),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
`ifdef LSU_STATS_EN
        ,
        .stat_loads     (stat_loads),
        .stat_stores    (stat_stores),
        .stat_faults    (stat_faults)
`endif
    );

    assign mem_read_data = mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_address[11:2]] <= mem_write_data;
            write_pulses <= write_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request at the negedge; return #1 after the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // Load or fault: response expected in the cycle after accept.
    task automatic load_or_fault(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [11:0] addr, input logic [31:0] exp_data,
                                 input logic exp_mis, input logic exp_ill);
        int wp;
        wp = write_pulses;
        issue(we, f3, addr, 32'hFFFF_FFFF);
        $display("req %s we=%0d f3=%b addr=%h -> rdata=%h mis=%0d ill=%0d",
                 tag, we, f3, addr, rsp_rdata, rsp_misaligned, rsp_illegal);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rdata"}, rsp_rdata, exp_data);
        check({tag, "_mis"}, {31'd0, rsp_misaligned}, {31'd0, exp_mis});
        check({tag, "_ill"}, {31'd0, rsp_illegal}, {31'd0, exp_ill});
        check({tag, "_nowe"}, {31'd0, mem_write_en}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_wcnt"}, write_pulses, wp);
    endtask

    // Good store: one write pulse the cycle after accept, response the cycle after that.
    task automatic store(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_word);
        int wp;
        wp = write_pulses;
        issue(1'b1, f3, addr, wdata);
        $display("req %s store f3=%b addr=%h wdata=%h -> wr_en=%0d wr_data=%h",
                 tag, f3, addr, wdata, mem_write_en, mem_write_data);
        check({tag, "_we"}, {31'd0, mem_write_en}, 32'd1);
        check({tag, "_wdata"}, mem_write_data, exp_word);
        check({tag, "_nrsp"}, {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_we_off"}, {31'd0, mem_write_en}, 32'd0);
        check({tag, "_wcnt"}, write_pulses, wp + 1);
        check({tag, "_mem"}, mem[addr[11:2]], exp_word);
        @(posedge clk);
        #1;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[4]  = 32'h8000_00F0;
        mem[8]  = 32'h1122_3344;
        mem[12] = 32'h5555_5555;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_we", {31'd0, mem_write_en}, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Loads from word 0x8000_00F0 at 0x10
        load_or_fault("lb",  1'b0, 3'b000, 12'h010, 32'hFFFF_FFF0, 1'b0, 1'b0);
        load_or_fault("lbu", 1'b0, 3'b100, 12'h010, 32'h0000_00F0, 1'b0, 1'b0);
        load_or_fault("lh",  1'b0, 3'b001, 12'h012, 32'hFFFF_8000, 1'b0, 1'b0);
        load_or_fault("lhu", 1'b0, 3'b101, 12'h012, 32'h0000_8000, 1'b0, 1'b0);
        load_or_fault("lw",  1'b0, 3'b010, 12'h010, 32'h8000_00F0, 1'b0, 1'b0);

        // Read-modify-write stores on word 0x1122_3344 at 0x20
        store("sb", 3'b000, 12'h021, 32'hFFFF_FFAB, 32'h1122_AB44);
        store("sh", 3'b001, 12'h022, 32'h1234_BEEF, 32'hBEEF_AB44);
        load_or_fault("lw2", 1'b0, 3'b010, 12'h020, 32'hBEEF_AB44, 1'b0, 1'b0);

        // Faults
        load_or_fault("lw_mis",  1'b0, 3'b010, 12'h021, 32'd0, 1'b1, 1'b0);
        load_or_fault("sh_mis",  1'b1, 3'b001, 12'h023, 32'd0, 1'b1, 1'b0);
        load_or_fault("sbu_ill", 1'b1, 3'b100, 12'h020, 32'd0, 1'b0, 1'b1);
        load_or_fault("f011_ill", 1'b0, 3'b011, 12'h021, 32'd0, 1'b0, 1'b1);
        check("mem_after_faults", mem[8], 32'hBEEF_AB44);

`ifdef LSU_STATS_EN
        check("stat_loads", stat_loads, 32'd6);
        check("stat_stores", stat_stores, 32'd2);
        check("stat_faults", stat_faults, 32'd4);
`endif

        // Reset during WRITE suppresses the pending write
        issue(1'b1, 3'b010, 12'h030, 32'hDEAD_BEEF);
        $display("req sw_rst addr=030 wdata=DEADBEEF -> wr_en=%0d before reset", mem_write_en);
        check("sw_rst_we_pre", {31'd0, mem_write_en}, 32'd1);
        rst = 1'b0;
        #1;
        check("sw_rst_we_drop", {31'd0, mem_write_en}, 32'd0);
        check("sw_rst_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("sw_rst_ready", {31'd0, req_ready}, 32'd1);
        check("sw_rst_mem", mem[12], 32'h5555_5555);
`ifdef LSU_STATS_EN
        check("stat_rst", stat_loads | stat_stores | stat_faults, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
